// File: rtl/shader_core_loader.sv
// Host-side loader for the shader core: streams header/payload words into the
// core's instruction/data RAM, then resets and runs the core until halt or timeout.
module shader_core_loader #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int COUNT_WIDTH    = 14
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     core_reset_n,
  output logic                     run,
  input  logic                     halted,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [31:0]              ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     timed_out,
  output logic                     bad_cmd,
  output logic [31:0]              run_cycles
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] CORE_RST = 3'd2;
  localparam logic [2:0] RUN      = 3'd3;
  localparam logic [2:0] DONE_ST  = 3'd4;
  localparam logic [2:0] ABORT    = 3'd5;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd1;

  logic [2:0]               state;
  logic [2:0]               state_next;
  logic                     started;
  logic                     target_data;
  logic [COUNT_WIDTH-1:0]   remaining;
  logic [ADDRESS_WIDTH-1:0] addr_ptr;

  logic                     accept;
  logic [1:0]               hdr_op;
  logic [COUNT_WIDTH-1:0]   hdr_count;
  logic [15:0]              hdr_base_raw;
  logic [31:0]              rc_next;
  logic                     timeout_hit;

  assign accept       = in_valid && in_ready;
  assign hdr_op       = in_data[31:30];
  assign hdr_count    = in_data[16 +: COUNT_WIDTH];
  assign hdr_base_raw = in_data[15:0] & 16'hFFFC;
  assign rc_next      = (run_cycles == '1) ? run_cycles : run_cycles + 32'd1;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (rc_next >= TIMEOUT_LIMIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (hdr_op)
            2'b00, 2'b01: if (hdr_count != '0) state_next = LOAD;
            2'b10:        state_next = CORE_RST;
            default:      state_next = IDLE;
          endcase
        end
      end
      LOAD:     if (accept && remaining == COUNT_WIDTH'(1)) state_next = IDLE;
      CORE_RST: state_next = RUN;
      // halted is stale during the first RUN cycle (run_cycles still 0)
      RUN: begin
        if (halted && run_cycles != '0) state_next = DONE_ST;
        else if (timeout_hit)           state_next = ABORT;
      end
      DONE_ST:  state_next = IDLE;
      ABORT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                 <= IDLE;
      started               <= 1'b0;
      target_data           <= 1'b0;
      remaining             <= '0;
      addr_ptr              <= '0;
      in_ready              <= 1'b1;
      core_reset_n          <= 1'b0;
      run                   <= 1'b0;
      ext_write_address     <= '0;
      ext_write_data        <= '0;
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      timed_out             <= 1'b0;
      bad_cmd               <= 1'b0;
      run_cycles            <= '0;
    end else begin
      state                 <= state_next;
      in_ready              <= (state_next == IDLE) || (state_next == LOAD);
      run                   <= (state_next == RUN);
      busy                  <= (state_next != IDLE);
      done                  <= (state_next == DONE_ST);
      timed_out             <= (state_next == ABORT);
      core_reset_n          <= (state_next != CORE_RST) && (started || (state == IDLE && accept));
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;

      if (state == IDLE && accept) begin
        started     <= 1'b1;
        remaining   <= hdr_count;
        addr_ptr    <= ADDRESS_WIDTH'(hdr_base_raw);
        target_data <= hdr_op[0];
        if (hdr_op == 2'b11) bad_cmd <= 1'b1;
      end

      if (state == LOAD && accept) begin
        ext_write_address     <= addr_ptr;
        ext_write_data        <= in_data;
        ext_enable_write_inst <= !target_data;
        ext_enable_write_data <= target_data;
        addr_ptr              <= addr_ptr + ADDRESS_WIDTH'(4);
        remaining             <= remaining - COUNT_WIDTH'(1);
      end

      if (state_next == CORE_RST) run_cycles <= '0;
      else if (state == RUN)      run_cycles <= rc_next;
    end
  end

endmodule

// File: tb/tb_shader_core_loader.sv
// Directed self-checking bench for shader_core_loader (timeout set to 16 cycles).
module tb_shader_core_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_reset_n;
  logic        run;
  logic        halted;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic        bad_cmd;
  logic [31:0] run_cycles;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clock = ~clock;

  shader_core_loader #(
    .ADDRESS_WIDTH (16),
    .TIMEOUT_CYCLES(16),
    .COUNT_WIDTH   (14)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .core_reset_n         (core_reset_n),
    .run                  (run),
    .halted               (halted),
    .ext_write_address    (ext_write_address),
    .ext_write_data       (ext_write_data),
    .ext_enable_write_inst(ext_enable_write_inst),
    .ext_enable_write_data(ext_enable_write_data),
    .busy                 (busy),
    .done                 (done),
    .timed_out            (timed_out),
    .bad_cmd              (bad_cmd),
    .run_cycles           (run_cycles)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready), 32'd1);
    chk({tag, ".core_rst"},  32'(core_reset_n), 32'd0);
    chk({tag, ".run"},       32'(run), 32'd0);
    chk({tag, ".inst_we"},   32'(ext_enable_write_inst), 32'd0);
    chk({tag, ".data_we"},   32'(ext_enable_write_data), 32'd0);
    chk({tag, ".addr"},      32'(ext_write_address), 32'd0);
    chk({tag, ".wdata"},     ext_write_data, 32'd0);
    chk({tag, ".busy"},      32'(busy), 32'd0);
    chk({tag, ".done"},      32'(done), 32'd0);
    chk({tag, ".timed_out"}, 32'(timed_out), 32'd0);
    chk({tag, ".bad_cmd"},   32'(bad_cmd), 32'd0);
    chk({tag, ".run_cycles"}, run_cycles, 32'd0);
  endtask

  task automatic chk_strobe(input string tag, input logic inst, input logic data,
                            input logic [15:0] addr, input logic [31:0] wd);
    chk({tag, ".inst_we"}, 32'(ext_enable_write_inst), 32'(inst));
    chk({tag, ".data_we"}, 32'(ext_enable_write_data), 32'(data));
    if (inst || data) begin
      chk({tag, ".addr"},  32'(ext_write_address), 32'(addr));
      chk({tag, ".wdata"}, ext_write_data, wd);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    halted   = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    reset_n = 1'b1;

    // Instruction load, three back-to-back words
    in_valid = 1'b1; in_data = 32'h0003_0100;
    tick();
    chk("l1.busy", 32'(busy), 32'd1);
    chk("l1.core_rst", 32'(core_reset_n), 32'd1);
    chk_strobe("l1.hdr", 1'b0, 1'b0, 16'h0, 32'h0);
    in_data = 32'hAAAA_0001; tick();
    chk_strobe("l1.w0", 1'b1, 1'b0, 16'h0100, 32'hAAAA_0001);
    in_data = 32'hBBBB_0002; tick();
    chk_strobe("l1.w1", 1'b1, 1'b0, 16'h0104, 32'hBBBB_0002);
    in_data = 32'hCCCC_0003; tick();
    chk_strobe("l1.w2", 1'b1, 1'b0, 16'h0108, 32'hCCCC_0003);
    chk("l1.busy_end", 32'(busy), 32'd0);
    in_valid = 1'b0; tick();
    chk_strobe("l1.after", 1'b0, 1'b0, 16'h0, 32'h0);

    // Data load with gaps; base low bits ignored
    in_valid = 1'b1; in_data = 32'h4002_0FFE; tick();
    chk("l2.busy", 32'(busy), 32'd1);
    in_valid = 1'b0; tick();
    chk_strobe("l2.gap0", 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk_strobe("l2.gap1", 1'b0, 1'b0, 16'h0, 32'h0);
    in_valid = 1'b1; in_data = 32'hD00D_0000; tick();
    chk_strobe("l2.w0", 1'b0, 1'b1, 16'h0FFC, 32'hD00D_0000);
    in_valid = 1'b0; tick();
    chk_strobe("l2.gap2", 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    chk_strobe("l2.gap3", 1'b0, 1'b0, 16'h0, 32'h0);
    in_valid = 1'b1; in_data = 32'hE00E_0001; tick();
    chk_strobe("l2.w1", 1'b0, 1'b1, 16'h1000, 32'hE00E_0001);
    chk("l2.busy_end", 32'(busy), 32'd0);
    in_valid = 1'b0; tick();
    chk_strobe("l2.after", 1'b0, 1'b0, 16'h0, 32'h0);

    // Run that halts after 4 run cycles; stale halted in first cycle ignored
    in_valid = 1'b1; in_data = 32'h8000_0000; tick();
    in_valid = 1'b0;
    chk("r1.crst.core_rst", 32'(core_reset_n), 32'd0);
    chk("r1.crst.in_ready", 32'(in_ready), 32'd0);
    chk("r1.crst.run", 32'(run), 32'd0);
    chk("r1.crst.rc", run_cycles, 32'd0);
    halted = 1'b1; tick();
    chk("r1.c0.run", 32'(run), 32'd1);
    chk("r1.c0.core_rst", 32'(core_reset_n), 32'd1);
    chk("r1.c0.rc", run_cycles, 32'd0);
    tick();
    chk("r1.c1.run", 32'(run), 32'd1);
    chk("r1.c1.done", 32'(done), 32'd0);
    chk("r1.c1.rc", run_cycles, 32'd1);
    halted = 1'b0; tick();
    chk("r1.c2.rc", run_cycles, 32'd2);
    chk("r1.c2.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("r1.c3.rc", run_cycles, 32'd3);
    chk("r1.c3.run", 32'(run), 32'd1);
    halted = 1'b1; tick();
    chk("r1.done", 32'(done), 32'd1);
    chk("r1.done.run", 32'(run), 32'd0);
    chk("r1.done.rc", run_cycles, 32'd4);
    chk("r1.done.in_ready", 32'(in_ready), 32'd0);
    chk("r1.done.busy", 32'(busy), 32'd1);
    halted = 1'b0; tick();
    chk("r1.idle.done", 32'(done), 32'd0);
    chk("r1.idle.busy", 32'(busy), 32'd0);
    chk("r1.idle.in_ready", 32'(in_ready), 32'd1);
    chk("r1.idle.rc_hold", run_cycles, 32'd4);

    // Run that never halts: abort after 15 run cycles
    in_valid = 1'b1; in_data = 32'h8000_0000; tick();
    in_valid = 1'b0;
    chk("r2.crst.core_rst", 32'(core_reset_n), 32'd0);
    chk("r2.crst.rc", run_cycles, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("r2.loop.run", 32'(run), 32'd1);
      chk("r2.loop.rc", run_cycles, 32'(k - 1));
      chk("r2.loop.to", 32'(timed_out), 32'd0);
    end
    tick();
    chk("r2.abort.to", 32'(timed_out), 32'd1);
    chk("r2.abort.run", 32'(run), 32'd0);
    chk("r2.abort.rc", run_cycles, 32'd15);
    chk("r2.abort.done", 32'(done), 32'd0);
    tick();
    chk("r2.idle.to", 32'(timed_out), 32'd0);
    chk("r2.idle.in_ready", 32'(in_ready), 32'd1);
    chk("r2.idle.rc_hold", run_cycles, 32'd15);

    // Reserved opcode, then a normal one-word load
    in_valid = 1'b1; in_data = 32'hC000_0000; tick();
    chk("bc.bad_cmd", 32'(bad_cmd), 32'd1);
    chk("bc.busy", 32'(busy), 32'd0);
    chk_strobe("bc.no_we", 1'b0, 1'b0, 16'h0, 32'h0);
    in_data = 32'h0001_0010; tick();
    chk("bc.l.busy", 32'(busy), 32'd1);
    chk("bc.l.sticky", 32'(bad_cmd), 32'd1);
    in_data = 32'hDEAD_0001; tick();
    chk_strobe("bc.l.w0", 1'b1, 1'b0, 16'h0010, 32'hDEAD_0001);
    chk("bc.l.busy_end", 32'(busy), 32'd0);

    // Reset in the middle of a four-word load
    in_data = 32'h4004_0200; tick();
    in_data = 32'h1111_0000; tick();
    chk_strobe("mr.w0", 1'b0, 1'b1, 16'h0200, 32'h1111_0000);
    in_data = 32'h2222_0000; reset_n = 1'b0; tick();
    chk_reset_state("mr.rst");
    reset_n = 1'b1; in_valid = 1'b0; tick();
    chk_strobe("mr.post", 1'b0, 1'b0, 16'h0, 32'h0);
    chk("mr.post.busy", 32'(busy), 32'd0);
    chk("mr.post.core_rst", 32'(core_reset_n), 32'd0);
    in_valid = 1'b1; in_data = 32'h0001_0040; tick();
    chk("mr.l.busy", 32'(busy), 32'd1);
    chk("mr.l.core_rst", 32'(core_reset_n), 32'd1);
    in_data = 32'h3333_4444; tick();
    chk_strobe("mr.l.w0", 1'b1, 1'b0, 16'h0040, 32'h3333_4444);
    in_valid = 1'b0; tick();
    chk_strobe("mr.l.after", 1'b0, 1'b0, 16'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
